// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, FSM state type and op helpers
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_NE  = 4'b1010;
  localparam logic [3:0] OP_LT  = 4'b1100;
  localparam logic [3:0] OP_GE  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_e;

  // Shifts are the only ops that go through the iterative path.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - single-cycle ALU datapath (everything except shifts)
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  logic w_lt_signed;

  assign w_lt_signed = $signed(i_a) < $signed(i_b);

  // Decode the op; shift and unknown codes yield 0 here.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_EQ:   o_result = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
      OP_NE:   o_result = {{(WIDTH-1){1'b0}}, (i_a != i_b)};
      OP_LT:   o_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
      OP_GE:   o_result = {{(WIDTH-1){1'b0}}, ~w_lt_signed};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - ALU with one-bit-per-cycle shifter and valid/ready handshakes
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  alu_state_e         r_state;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_shreg;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_out_valid;

  logic [WIDTH-1:0]   w_comb_result;
  logic [WIDTH-1:0]   w_shift_next;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt   = srcb[SHAMT_W-1:0];
  // rst_n is used directly so in_ready drops the moment reset asserts.
  assign in_ready  = rst_n & ~flush & (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign busy      = (r_state != ST_IDLE);

  alu_comb_core #(
    .WIDTH(WIDTH)
  ) u_comb_core (
    .i_op     (operation),
    .i_a      (srca),
    .i_b      (srcb),
    .o_result (w_comb_result)
  );

  // One-bit shift step; SRA keeps re-copying the original sign bit.
  always_comb begin
    w_shift_next = r_shreg;
    case (r_op)
      OP_SLL:  w_shift_next = {r_shreg[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shift_next = {1'b0, r_shreg[WIDTH-1:1]};
      OP_SRA:  w_shift_next = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      default: w_shift_next = r_shreg;
    endcase
  end

  // Control FSM; flush outranks accept and out_ready, result stays 0 unless valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_AND;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= operation;
            r_shreg <= srca;
            if (is_shift_op(operation) && (w_shamt != '0)) begin
              r_cnt   <= w_shamt;
              r_state <= ST_SHIFT;
            end else begin
              r_result    <= is_shift_op(operation) ? srca : w_comb_result;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_shreg <= w_shift_next;
          r_cnt   <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result    <= w_shift_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_result    <= '0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
